// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared types and constants for the LASER scan controller
package laser_pkg;

    localparam int GRID_W = 4;
    localparam int CNT_W  = 7;
    localparam logic [GRID_W-1:0] GRID_MAX = GRID_W'(15);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_C2,
        ST_SCAN_C1,
        ST_CHECK,
        ST_OUT
    } state_t;

endpackage

// File: rtl/laser_best_tracker.sv
// rtl/laser_best_tracker.sv - per-candidate hit count and best-centre tracking
module laser_best_tracker
    import laser_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              pt_first,
    input  logic              pt_last,
    input  logic              hit_cand,
    input  logic              hit_fix,
    input  logic [GRID_W-1:0] cand_x,
    input  logic [GRID_W-1:0] cand_y,
    input  logic [GRID_W-1:0] inc_x,
    input  logic [GRID_W-1:0] inc_y,
    output logic [GRID_W-1:0] best_x_nxt,
    output logic [GRID_W-1:0] best_y_nxt
);

    logic [CNT_W-1:0]  cnt, cnt_final, best_cnt, eff_cnt, best_cnt_nxt;
    logic [GRID_W-1:0] best_x, best_y, eff_x, eff_y;
    logic              take;

    // clear substitutes the incumbent in the same cycle so a one-point phase still compares correctly
    always_comb begin
        cnt_final    = (pt_first ? '0 : cnt) + CNT_W'(hit_cand & ~hit_fix);
        eff_cnt      = clear ? '0 : best_cnt;
        eff_x        = clear ? inc_x : best_x;
        eff_y        = clear ? inc_y : best_y;
        take         = pt_last && ((cnt_final > eff_cnt) ||
                       ((cnt_final == eff_cnt) && (cand_x == inc_x) && (cand_y == inc_y)));
        best_cnt_nxt = take ? cnt_final : eff_cnt;
        best_x_nxt   = take ? cand_x : eff_x;
        best_y_nxt   = take ? cand_y : eff_y;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt      <= '0;
            best_cnt <= '0;
            best_x   <= '0;
            best_y   <= '0;
        end else begin
            cnt      <= cnt_final;
            best_cnt <= best_cnt_nxt;
            best_x   <= best_x_nxt;
            best_y   <= best_y_nxt;
        end
    end

endmodule

// File: rtl/laser_scan_ctrl.sv
// rtl/laser_scan_ctrl.sv - alternating two-circle centre search over a 16x16 grid
module laser_scan_ctrl
    import laser_pkg::*;
#(
    parameter int N_PTS    = 40,
    parameter int MAX_ITER = 8,
    parameter int INIT_C1X = 0,
    parameter int INIT_C1Y = 0,
    parameter int INIT_C2X = 0,
    parameter int INIT_C2Y = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic [5:0]        pt_idx,
    output logic [GRID_W-1:0] cand_x,
    output logic [GRID_W-1:0] cand_y,
    output logic [GRID_W-1:0] fix_x,
    output logic [GRID_W-1:0] fix_y,
    input  logic              hit_cand,
    input  logic              hit_fix,
    output logic              busy,
    output logic [GRID_W-1:0] C1X,
    output logic [GRID_W-1:0] C1Y,
    output logic [GRID_W-1:0] C2X,
    output logic [GRID_W-1:0] C2Y,
    output logic              DONE
);

    state_t            state, state_nxt;
    logic [5:0]        px;
    logic [GRID_W-1:0] cx, cy, c1x, c1y, c2x, c2y, inc_x, inc_y, nxt_x, nxt_y;
    logic [3:0]        iter, iter_inc;
    logic              changed, scanning, scan_c2, pt_last, phase_first, phase_end, finish;

    always_comb begin
        scanning    = (state == ST_SCAN_C2) || (state == ST_SCAN_C1);
        scan_c2     = (state == ST_SCAN_C2);
        inc_x       = scan_c2 ? c2x : c1x;
        inc_y       = scan_c2 ? c2y : c1y;
        pt_last     = scanning && (px == 6'(N_PTS - 1));
        phase_first = scanning && (px == '0) && (cx == '0) && (cy == '0);
        phase_end   = pt_last && (cx == GRID_MAX) && (cy == GRID_MAX);
        iter_inc    = iter + 4'd1;
        finish      = !changed || (iter_inc == 4'(MAX_ITER));
        pt_idx      = scanning ? px : '0;
        cand_x      = scanning ? cx : '0;
        cand_y      = scanning ? cy : '0;
        fix_x       = scanning ? (scan_c2 ? c1x : c2x) : '0;
        fix_y       = scanning ? (scan_c2 ? c1y : c2y) : '0;
        busy        = (state != ST_IDLE);
    end

    laser_best_tracker u_tracker (
        .clk        (CLK),
        .resetn     (RST),
        .clear      (phase_first),
        .pt_first   (px == '0),
        .pt_last    (pt_last),
        .hit_cand   (hit_cand),
        .hit_fix    (hit_fix),
        .cand_x     (cx),
        .cand_y     (cy),
        .inc_x      (inc_x),
        .inc_y      (inc_y),
        .best_x_nxt (nxt_x),
        .best_y_nxt (nxt_y)
    );

    always_ff @(posedge CLK) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_SCAN_C2;
            ST_SCAN_C2: if (phase_end) state_nxt = ST_SCAN_C1;
            ST_SCAN_C1: if (phase_end) state_nxt = ST_CHECK;
            ST_CHECK:   state_nxt = finish ? ST_OUT : ST_SCAN_C2;
            ST_OUT:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            px <= '0;  cx <= '0;  cy <= '0;
            c1x <= '0; c1y <= '0; c2x <= '0; c2y <= '0;
            iter <= '0; changed <= 1'b0;
            C1X <= '0; C1Y <= '0; C2X <= '0; C2Y <= '0;
            DONE <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        c1x <= GRID_W'(INIT_C1X); c1y <= GRID_W'(INIT_C1Y);
                        c2x <= GRID_W'(INIT_C2X); c2y <= GRID_W'(INIT_C2Y);
                        iter <= '0; changed <= 1'b0;
                        px <= '0; cx <= '0; cy <= '0;
                    end
                end
                ST_SCAN_C2, ST_SCAN_C1: begin
                    // raster wraps naturally to (0,0,0) at phase end
                    if (pt_last) begin
                        px <= '0;
                        cx <= cx + 1'b1;
                        if (cx == GRID_MAX) cy <= cy + 1'b1;
                    end else begin
                        px <= px + 1'b1;
                    end
                    if (phase_end) begin
                        if (scan_c2) begin c2x <= nxt_x; c2y <= nxt_y; end
                        else         begin c1x <= nxt_x; c1y <= nxt_y; end
                        changed <= changed | ({nxt_x, nxt_y} != {inc_x, inc_y});
                    end
                end
                ST_CHECK: begin
                    iter <= iter_inc;
                    if (finish) begin
                        C1X <= c1x; C1Y <= c1y; C2X <= c2x; C2Y <= c2y;
                        DONE <= 1'b1;
                    end else begin
                        changed <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// tb/tb_laser_scan_ctrl.sv - scoreboard bench for laser_scan_ctrl
module tb_laser_scan_ctrl;

    localparam int NP   = 8;
    localparam int PASS = 512 * NP + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b;
    logic [5:0] pt_idx_a, pt_idx_b;
    logic [3:0] cand_x_a, cand_y_a, fix_x_a, fix_y_a, c1x_a, c1y_a, c2x_a, c2y_a;
    logic [3:0] cand_x_b, cand_y_b, fix_x_b, fix_y_b, c1x_b, c1y_b, c2x_b, c2y_b;
    logic       hit_cand_a, hit_fix_a, busy_a, done_a;
    logic       hit_cand_b, hit_fix_b, busy_b, done_b;

    logic [3:0] pts_x [64];
    logic [3:0] pts_y [64];

    laser_scan_ctrl #(.N_PTS(NP), .MAX_ITER(8)) dut_a (
        .CLK(clk), .RST(rst), .start(start_a), .pt_idx(pt_idx_a),
        .cand_x(cand_x_a), .cand_y(cand_y_a), .fix_x(fix_x_a), .fix_y(fix_y_a),
        .hit_cand(hit_cand_a), .hit_fix(hit_fix_a), .busy(busy_a),
        .C1X(c1x_a), .C1Y(c1y_a), .C2X(c2x_a), .C2Y(c2y_a), .DONE(done_a)
    );

    laser_scan_ctrl #(.N_PTS(NP), .MAX_ITER(1)) dut_b (
        .CLK(clk), .RST(rst), .start(start_b), .pt_idx(pt_idx_b),
        .cand_x(cand_x_b), .cand_y(cand_y_b), .fix_x(fix_x_b), .fix_y(fix_y_b),
        .hit_cand(hit_cand_b), .hit_fix(hit_fix_b), .busy(busy_b),
        .C1X(c1x_b), .C1Y(c1y_b), .C2X(c2x_b), .C2Y(c2y_b), .DONE(done_b)
    );

    function automatic logic in_circle(input logic [3:0] px, py, cx, cy);
        int dx, dy;
        dx = int'(px) - int'(cx);
        dy = int'(py) - int'(cy);
        return (dx * dx + dy * dy) <= 16;
    endfunction

    always_comb begin
        hit_cand_a = in_circle(pts_x[pt_idx_a], pts_y[pt_idx_a], cand_x_a, cand_y_a);
        hit_fix_a  = in_circle(pts_x[pt_idx_a], pts_y[pt_idx_a], fix_x_a, fix_y_a);
        hit_cand_b = in_circle(pts_x[pt_idx_b], pts_y[pt_idx_b], cand_x_b, cand_y_b);
        hit_fix_b  = in_circle(pts_x[pt_idx_b], pts_y[pt_idx_b], fix_x_b, fix_y_b);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        int c1x, c1y, c2x, c2y;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    int n_cmp = 0;
    int n_err = 0;
    int s_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (q_a.size() == 0) check("a_spurious_done", 1, 0);
            else begin
                e = q_a.pop_front();
                check("a_done_cycle", cyc, e.at);
                check("a_c1x", 32'(c1x_a), e.c1x);
                check("a_c1y", 32'(c1y_a), e.c1y);
                check("a_c2x", 32'(c2x_a), e.c2x);
                check("a_c2y", 32'(c2y_a), e.c2y);
            end
        end
        if (done_b) begin
            if (q_b.size() == 0) check("b_spurious_done", 1, 0);
            else begin
                e = q_b.pop_front();
                check("b_done_cycle", cyc, e.at);
                check("b_c1x", 32'(c1x_b), e.c1x);
                check("b_c1y", 32'(c1y_b), e.c1y);
                check("b_c2x", 32'(c2x_b), e.c2x);
                check("b_c2y", 32'(c2y_b), e.c2y);
            end
        end
    end

    task automatic load_pts(input int mode);
        for (int i = 0; i < 64; i++) begin
            if (mode == 0 || i < NP / 2) begin
                pts_x[i] = (mode == 0) ? 4'd5 : 4'd3;
                pts_y[i] = (mode == 0) ? 4'd5 : 4'd3;
            end else begin
                pts_x[i] = 4'd12;
                pts_y[i] = 4'd12;
            end
        end
    endtask

    task automatic kick(input int k, input int c1x, c1y, c2x, c2y, input bit with_b);
        @(posedge clk);
        #1;
        start_a = 1'b1;
        s_a = cyc;
        q_a.push_back('{s_a + 1 + k * PASS, c1x, c1y, c2x, c2y});
        if (with_b) begin
            start_b = 1'b1;
            q_b.push_back('{s_a + 1 + PASS, c1x, c1y, c2x, c2y});
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic at_rel(input int r);
        do @(negedge clk); while (cyc < s_a + r);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("drain_pending", q_a.size() + q_b.size(), 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy_a), 0);
        check({tag, "_done"}, 32'(done_a), 0);
        check({tag, "_scan_outs"}, {pt_idx_a, cand_x_a, cand_y_a, fix_x_a, fix_y_a}, 0);
        check({tag, "_centres"}, {c1x_a, c1y_a, c2x_a, c2y_a}, 0);
    endtask

    initial begin
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        load_pts(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // raster plus cluster at (5,5); B runs the same data with one pass
        kick(2, 0, 0, 5, 1, 1'b1);
        @(negedge clk);
        check("r1_busy", 32'(busy_a), 1);
        check("r1_cand_pt", {cand_x_a, cand_y_a, pt_idx_a}, 0);
        check("r1_fix", {fix_x_a, fix_y_a}, 0);
        at_rel(NP);
        check("r_last_pt", 32'(pt_idx_a), NP - 1);
        check("r_last_cand", {cand_x_a, cand_y_a}, 0);
        at_rel(NP + 1);
        check("r_next_cand", {cand_x_a, cand_y_a, pt_idx_a}, {4'd1, 4'd0, 6'd0});
        at_rel(256 * NP + 1);
        check("c1_phase_fix", {fix_x_a, fix_y_a}, {4'd5, 4'd1});
        check("c1_phase_cand", {cand_x_a, cand_y_a, pt_idx_a}, 0);
        drain(3 * PASS);
        check("after_done_busy", 32'(busy_a), 0);
        check("hold_c2", {c2x_a, c2y_a}, {4'd5, 4'd1});

        // two clusters
        load_pts(1);
        kick(2, 12, 8, 1, 0, 1'b0);
        drain(3 * PASS);

        // a second start while busy must be ignored
        load_pts(0);
        kick(2, 0, 0, 5, 1, 1'b0);
        at_rel(3000);
        @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        drain(3 * PASS);

        // reset mid-scan, then a clean rerun
        kick(2, 0, 0, 5, 1, 1'b0);
        at_rel(1000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_a.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("midreset");
        kick(2, 0, 0, 5, 1, 1'b0);
        drain(3 * PASS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
